// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester and downstream signal bundle for bus_arbiter
interface bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // requester A (Wishbone host path)
  logic                  a_valid_i;
  logic                  a_we_i;
  logic [STRB_WIDTH-1:0] a_wstrb_i;
  logic [ADDR_WIDTH-1:0] a_addr_i;
  logic [DATA_WIDTH-1:0] a_wdata_i;
  logic                  a_ready_o;
  logic [DATA_WIDTH-1:0] a_rdata_o;
  logic                  a_err_o;

  // requester B (UART command path)
  logic                  b_valid_i;
  logic                  b_we_i;
  logic [STRB_WIDTH-1:0] b_wstrb_i;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic [DATA_WIDTH-1:0] b_wdata_i;
  logic                  b_ready_o;
  logic [DATA_WIDTH-1:0] b_rdata_o;
  logic                  b_err_o;

  // shared downstream register port
  logic                  m_valid_o;
  logic                  m_we_o;
  logic [STRB_WIDTH-1:0] m_wstrb_o;
  logic [ADDR_WIDTH-1:0] m_addr_o;
  logic [DATA_WIDTH-1:0] m_wdata_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_rdata_i;

  logic [1:0]            grant_o;

  // arbiter side
  modport slave (
    input  a_valid_i, a_we_i, a_wstrb_i, a_addr_i, a_wdata_i,
    input  b_valid_i, b_we_i, b_wstrb_i, b_addr_i, b_wdata_i,
    input  m_ready_i, m_rdata_i,
    output a_ready_o, a_rdata_o, a_err_o,
    output b_ready_o, b_rdata_o, b_err_o,
    output m_valid_o, m_we_o, m_wstrb_o, m_addr_o, m_wdata_o,
    output grant_o
  );

  // requesters plus downstream responder, as seen from outside the arbiter
  modport master (
    output a_valid_i, a_we_i, a_wstrb_i, a_addr_i, a_wdata_i,
    output b_valid_i, b_we_i, b_wstrb_i, b_addr_i, b_wdata_i,
    output m_ready_i, m_rdata_i,
    input  a_ready_o, a_rdata_o, a_err_o,
    input  b_ready_o, b_rdata_o, b_err_o,
    input  m_valid_o, m_we_o, m_wstrb_o, m_addr_o, m_wdata_o,
    input  grant_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester round-robin register-port arbiter (optional abort: ARB_TIMEOUT_EN)
module bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // r_last / r_owner_b: 0 = requester A, 1 = requester B
  logic                  r_last;
  logic                  r_owner_b;
  logic [1:0]            r_grant;

  logic                  r_m_valid;
  logic                  r_m_we;
  logic [STRB_WIDTH-1:0] r_m_wstrb;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [DATA_WIDTH-1:0] r_m_wdata;

  logic                  r_a_ready;
  logic                  r_b_ready;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;

  logic                  w_win_b;
  logic                  w_start;
  logic                  w_complete;
  logic                  w_abort;
  logic [DATA_WIDTH-1:0] w_resp_data;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    w_win_b = 1'b0;
    if (bus.a_valid_i && bus.b_valid_i) begin
      w_win_b = ~r_last;
    end else if (bus.b_valid_i) begin
      w_win_b = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transaction strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.a_valid_i || bus.b_valid_i) begin
          w_start     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // a real acknowledge always beats an abort in the same cycle
        if (bus.m_ready_i) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_abort) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Aborted transactions answer with all-ones
  assign w_resp_data = w_complete ? bus.m_rdata_i : {DATA_WIDTH{1'b1}};

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;
  logic        r_a_err;
  logic        r_b_err;

  // Abort when this unacknowledged BUSY edge would bring the count to TIMEOUT_CYCLES
  assign w_abort = (r_state == ST_BUSY) && !bus.m_ready_i && (r_cnt == LP_TO_LAST);

  // Count BUSY cycles without an acknowledge; restart on every new grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 16'd0;
    end else if (w_start) begin
      r_cnt <= 16'd0;
    end else if ((r_state == ST_BUSY) && !bus.m_ready_i) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Error flags pulse alongside ready only for an aborted transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_err <= 1'b0;
      r_b_err <= 1'b0;
    end else if ((r_state == ST_BUSY) && (w_complete || w_abort)) begin
      r_a_err <= w_abort && !r_owner_b;
      r_b_err <= w_abort &&  r_owner_b;
    end else if (r_state == ST_DONE) begin
      r_a_err <= 1'b0;
      r_b_err <= 1'b0;
    end
  end

  assign bus.a_err_o = r_a_err;
  assign bus.b_err_o = r_b_err;
`else
  logic [15:0] w_unused_timeout;

  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_abort          = 1'b0;
  assign bus.a_err_o      = 1'b0;
  assign bus.b_err_o      = 1'b0;
`endif

  // Request latch, grant tracking and response steering
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last    <= 1'b1;
      r_owner_b <= 1'b0;
      r_grant   <= 2'b00;
      r_m_valid <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_wstrb <= '0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_a_ready <= 1'b0;
      r_b_ready <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_owner_b <= w_win_b;
            r_grant   <= w_win_b ? 2'b10 : 2'b01;
            r_m_valid <= 1'b1;
            r_m_we    <= w_win_b ? bus.b_we_i    : bus.a_we_i;
            r_m_wstrb <= w_win_b ? bus.b_wstrb_i : bus.a_wstrb_i;
            r_m_addr  <= w_win_b ? bus.b_addr_i  : bus.a_addr_i;
            r_m_wdata <= w_win_b ? bus.b_wdata_i : bus.a_wdata_i;
          end
        end
        ST_BUSY: begin
          if (w_complete || w_abort) begin
            r_m_valid <= 1'b0;
            r_last    <= r_owner_b;
            if (r_owner_b) begin
              r_b_ready <= 1'b1;
              r_b_rdata <= w_resp_data;
            end else begin
              r_a_ready <= 1'b1;
              r_a_rdata <= w_resp_data;
            end
          end
        end
        ST_DONE: begin
          r_grant   <= 2'b00;
          r_a_ready <= 1'b0;
          r_b_ready <= 1'b0;
          r_a_rdata <= '0;
          r_b_rdata <= '0;
        end
        default: begin
          r_grant   <= 2'b00;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_o   = r_grant;
  assign bus.m_valid_o = r_m_valid;
  assign bus.m_we_o    = r_m_we;
  assign bus.m_wstrb_o = r_m_wstrb;
  assign bus.m_addr_o  = r_m_addr;
  assign bus.m_wdata_o = r_m_wdata;
  assign bus.a_ready_o = r_a_ready;
  assign bus.b_ready_o = r_b_ready;
  assign bus.a_rdata_o = r_a_rdata;
  assign bus.b_rdata_o = r_b_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  bus_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".m_valid"}, 64'(bus_if.m_valid_o), 64'd0);
    check({tag, ".grant"},   64'(bus_if.grant_o),   64'd0);
    check({tag, ".a_ready"}, 64'(bus_if.a_ready_o), 64'd0);
    check({tag, ".b_ready"}, 64'(bus_if.b_ready_o), 64'd0);
    check({tag, ".a_rdata"}, 64'(bus_if.a_rdata_o), 64'd0);
    check({tag, ".b_rdata"}, 64'(bus_if.b_rdata_o), 64'd0);
    check({tag, ".a_err"},   64'(bus_if.a_err_o),   64'd0);
    check({tag, ".b_err"},   64'(bus_if.b_err_o),   64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus_if.a_valid_i = 1'b0; bus_if.a_we_i = 1'b0; bus_if.a_wstrb_i = 4'h0;
    bus_if.a_addr_i  = 32'h0; bus_if.a_wdata_i = 32'h0;
    bus_if.b_valid_i = 1'b0; bus_if.b_we_i = 1'b0; bus_if.b_wstrb_i = 4'h0;
    bus_if.b_addr_i  = 32'h0; bus_if.b_wdata_i = 32'h0;
    bus_if.m_ready_i = 1'b0; bus_if.m_rdata_i = 32'h0;

    // reset state
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // reset mid-BUSY
    bus_if.a_valid_i = 1'b1;
    bus_if.a_addr_i  = 32'h0000_0010;
    tick();
    check("rst_mid.m_valid_pre", 64'(bus_if.m_valid_o), 64'd1);
    check("rst_mid.grant_pre",   64'(bus_if.grant_o),   64'h1);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid.m_addr", 64'(bus_if.m_addr_o), 64'd0);
    #1 rst = 1'b1;
    tick();
    check("rst_rel.m_valid", 64'(bus_if.m_valid_o), 64'd1);
    check("rst_rel.grant",   64'(bus_if.grant_o),   64'h1);
    bus_if.m_ready_i = 1'b1;
    tick();
    check("rst_rel.a_ready", 64'(bus_if.a_ready_o), 64'd1);
    bus_if.a_valid_i = 1'b0;
    bus_if.m_ready_i = 1'b0;
    tick();

    // single A read
    bus_if.a_valid_i = 1'b1;
    bus_if.a_we_i    = 1'b0;
    bus_if.a_addr_i  = 32'h3000_0004;
    tick();
    check("rdA.m_valid", 64'(bus_if.m_valid_o), 64'd1);
    check("rdA.m_addr",  64'(bus_if.m_addr_o),  64'h3000_0004);
    check("rdA.m_we",    64'(bus_if.m_we_o),    64'd0);
    check("rdA.grant",   64'(bus_if.grant_o),   64'h1);
    check("rdA.a_ready0",64'(bus_if.a_ready_o), 64'd0);
    bus_if.m_ready_i = 1'b1;
    bus_if.m_rdata_i = 32'h1234_5678;
    tick();
    check("rdA.a_ready", 64'(bus_if.a_ready_o), 64'd1);
    check("rdA.a_rdata", 64'(bus_if.a_rdata_o), 64'h1234_5678);
    check("rdA.b_ready", 64'(bus_if.b_ready_o), 64'd0);
    check("rdA.b_rdata", 64'(bus_if.b_rdata_o), 64'd0);
    check("rdA.a_err",   64'(bus_if.a_err_o),   64'd0);
    check("rdA.m_valid_clr", 64'(bus_if.m_valid_o), 64'd0);
    bus_if.a_valid_i = 1'b0;
    bus_if.m_ready_i = 1'b0;
    bus_if.m_rdata_i = 32'h0;
    tick();
    check("rdA.a_ready_drop", 64'(bus_if.a_ready_o), 64'd0);
    check("rdA.a_rdata_zero", 64'(bus_if.a_rdata_o), 64'd0);
    check("rdA.grant_clr",    64'(bus_if.grant_o),   64'h0);

    // B streams 4 transactions with A idle: ready after edges 2,5,8,11
    bus_if.b_valid_i = 1'b1;
    bus_if.b_we_i    = 1'b0;
    bus_if.b_addr_i  = 32'h0000_0200;
    bus_if.m_ready_i = 1'b1;
    bus_if.m_rdata_i = 32'hC0DE_0001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("strmB.b_ready[%0d]", k), 64'(bus_if.b_ready_o), 64'((k % 3) == 2));
      check($sformatf("strmB.a_ready[%0d]", k), 64'(bus_if.a_ready_o), 64'd0);
      if ((k % 3) == 2) begin
        check($sformatf("strmB.b_rdata[%0d]", k), 64'(bus_if.b_rdata_o), 64'hC0DE_0001);
      end
      if ((k % 3) == 1) begin
        check($sformatf("strmB.grant[%0d]", k), 64'(bus_if.grant_o), 64'h2);
      end
      if (k == 11) begin
        bus_if.b_valid_i = 1'b0;
      end
    end
    check("strmB.idle_after", 64'(bus_if.m_valid_o), 64'd0);

    // simultaneous A and B writes: A first (last was B), then B
    bus_if.a_valid_i = 1'b1; bus_if.a_we_i = 1'b1; bus_if.a_wstrb_i = 4'hF;
    bus_if.a_addr_i  = 32'h0000_0100; bus_if.a_wdata_i = 32'hAAAA_0001;
    bus_if.b_valid_i = 1'b1; bus_if.b_we_i = 1'b1; bus_if.b_wstrb_i = 4'h3;
    bus_if.b_addr_i  = 32'h0000_0200; bus_if.b_wdata_i = 32'hBBBB_0002;
    bus_if.m_ready_i = 1'b1;
    bus_if.m_rdata_i = 32'h0;
    tick();
    check("both.grantA",  64'(bus_if.grant_o),   64'h1);
    check("both.addrA",   64'(bus_if.m_addr_o),  64'h0000_0100);
    check("both.wdataA",  64'(bus_if.m_wdata_o), 64'hAAAA_0001);
    check("both.wstrbA",  64'(bus_if.m_wstrb_o), 64'hF);
    check("both.weA",     64'(bus_if.m_we_o),    64'd1);
    tick();
    check("both.a_ready", 64'(bus_if.a_ready_o), 64'd1);
    check("both.b_ready0",64'(bus_if.b_ready_o), 64'd0);
    check("both.gap_done",64'(bus_if.m_valid_o), 64'd0);
    bus_if.a_valid_i = 1'b0;
    tick();
    check("both.gap_idle",64'(bus_if.m_valid_o), 64'd0);
    check("both.gap_grant",64'(bus_if.grant_o),  64'h0);
    tick();
    check("both.grantB",  64'(bus_if.grant_o),   64'h2);
    check("both.addrB",   64'(bus_if.m_addr_o),  64'h0000_0200);
    check("both.wdataB",  64'(bus_if.m_wdata_o), 64'hBBBB_0002);
    check("both.wstrbB",  64'(bus_if.m_wstrb_o), 64'h3);
    check("both.m_validB",64'(bus_if.m_valid_o), 64'd1);
    tick();
    check("both.b_ready", 64'(bus_if.b_ready_o), 64'd1);
    check("both.a_ready1",64'(bus_if.a_ready_o), 64'd0);
    bus_if.b_valid_i = 1'b0;
    bus_if.m_ready_i = 1'b0;
    tick();

    // stall, with A withdrawing valid during BUSY
    bus_if.a_valid_i = 1'b1; bus_if.a_we_i = 1'b1; bus_if.a_wstrb_i = 4'h5;
    bus_if.a_addr_i  = 32'h0000_0044; bus_if.a_wdata_i = 32'h5555_AAAA;
    tick();
    bus_if.a_valid_i = 1'b0;
    bus_if.a_addr_i  = 32'hDEAD_0000;
    bus_if.a_wdata_i = 32'hDEAD_0000;
`ifdef ARB_TIMEOUT_EN
    for (int s = 0; s < 3; s++) begin
`else
    for (int s = 0; s < 10; s++) begin
`endif
      check($sformatf("stall.m_valid[%0d]", s), 64'(bus_if.m_valid_o), 64'd1);
      check($sformatf("stall.m_addr[%0d]", s),  64'(bus_if.m_addr_o),  64'h0000_0044);
      check($sformatf("stall.m_wdata[%0d]", s), 64'(bus_if.m_wdata_o), 64'h5555_AAAA);
      check($sformatf("stall.m_wstrb[%0d]", s), 64'(bus_if.m_wstrb_o), 64'h5);
      check($sformatf("stall.a_ready[%0d]", s), 64'(bus_if.a_ready_o), 64'd0);
      tick();
    end
    check("stall.m_valid_last", 64'(bus_if.m_valid_o), 64'd1);
    bus_if.m_ready_i = 1'b1;
    bus_if.m_rdata_i = 32'h0BAD_F00D;
    tick();
    check("stall.a_ready", 64'(bus_if.a_ready_o), 64'd1);
    check("stall.a_err",   64'(bus_if.a_err_o),   64'd0);
    check("stall.a_rdata", 64'(bus_if.a_rdata_o), 64'h0BAD_F00D);
    bus_if.m_ready_i = 1'b0;
    bus_if.m_rdata_i = 32'h0;
    tick();
    check("stall.a_ready_drop", 64'(bus_if.a_ready_o), 64'd0);

`ifdef ARB_TIMEOUT_EN
    // timeout: abort after the 4th unacknowledged BUSY edge
    bus_if.a_valid_i = 1'b1; bus_if.a_we_i = 1'b0; bus_if.a_addr_i = 32'h0000_0088;
    tick();
    check("to.m_valid", 64'(bus_if.m_valid_o), 64'd1);
    for (int t = 1; t <= 3; t++) begin
      tick();
      check($sformatf("to.a_ready[%0d]", t), 64'(bus_if.a_ready_o), 64'd0);
      check($sformatf("to.m_valid[%0d]", t), 64'(bus_if.m_valid_o), 64'd1);
    end
    tick();
    check("to.a_ready", 64'(bus_if.a_ready_o), 64'd1);
    check("to.a_err",   64'(bus_if.a_err_o),   64'd1);
    check("to.a_rdata", 64'(bus_if.a_rdata_o), 64'hFFFF_FFFF);
    check("to.m_valid_clr", 64'(bus_if.m_valid_o), 64'd0);
    bus_if.a_valid_i = 1'b0;
    tick();
    check("to.a_err_drop", 64'(bus_if.a_err_o), 64'd0);
    // following request is handled normally
    bus_if.a_valid_i = 1'b1;
    bus_if.m_ready_i = 1'b1;
    bus_if.m_rdata_i = 32'h0000_0077;
    tick();
    check("to_next.grant", 64'(bus_if.grant_o), 64'h1);
    tick();
    check("to_next.a_ready", 64'(bus_if.a_ready_o), 64'd1);
    check("to_next.a_err",   64'(bus_if.a_err_o),   64'd0);
    check("to_next.a_rdata", 64'(bus_if.a_rdata_o), 64'h0000_0077);
    bus_if.a_valid_i = 1'b0;
    bus_if.m_ready_i = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
